instruction_fetch: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Takes the current instruction address and issues one read at a time to instruction memory over a valid/ready request channel.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Back-pressures the PC through `pc_advance` and handles redirect flushes, including flushes that arrive while a request is outstanding.

---
 rtl/instruction_fetch_if.sv | 30 +++
 rtl/instruction_fetch.sv | 122 ++++++++++++
 tb/tb_instruction_fetch.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the decode-side handshake.
// master = fetch stage, slave = memory/decode environment.
interface instruction_fetch_if #(
   parameter int N = 32
);
   logic         imem_req_valid;
   logic         imem_req_ready;
   logic [N-1:0] imem_req_addr;
   logic         imem_resp_valid;
   logic [N-1:0] imem_resp_data;
   logic         if_valid;
   logic         if_ready;
   logic [N-1:0] if_pc;
   logic [N-1:0] if_instr;
   logic         if_misalign;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      output if_valid, if_pc, if_instr, if_misalign,
      input  if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      input  if_valid, if_pc, if_instr, if_misalign,
      output if_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request at a time, returned {pc, instr} pairs buffered for decode.
// Optional FETCH_MISALIGN_EN: misaligned PCs skip memory and push a flagged NOP entry directly.
module instruction_fetch #(
   parameter int N     = 32,
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        pc_in,
   output logic                pc_advance,
   input  logic                flush,
   instruction_fetch_if.master bus
);
   localparam int            AW      = $clog2(DEPTH);
   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [N-1:0]  NOP     = N'(32'h00000013);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  pc_mem    [DEPTH];
   logic [N-1:0]  instr_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] occ, count;
   logic [N-1:0]  req_pc;
   logic [N-1:0]  push_pc, push_instr;
   logic          slot_free, req_fire, resp_push, mis_push, push, pop, pc_misalign;

`ifdef FETCH_MISALIGN_EN
   logic mis_mem [DEPTH];
   assign pc_misalign = |pc_in[1:0];
`else
   assign pc_misalign = 1'b0;
`endif

   // The in-flight request already owns a slot, so a response can always be pushed.
   assign count     = occ + CW'(state_q == S_WAIT);
   assign slot_free = count < DEPTH_C;

   assign bus.imem_req_addr = pc_in;
   assign req_fire          = bus.imem_req_valid & bus.imem_req_ready;
   assign pc_advance        = req_fire | mis_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_REQ;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_REQ:  if (req_fire) state_d = S_WAIT;
         S_WAIT: begin
            if (bus.imem_resp_valid) state_d = S_REQ;
            else if (flush)          state_d = S_DROP;
         end
         S_DROP: if (bus.imem_resp_valid) state_d = S_REQ;
         default: state_d = S_REQ;
      endcase
   end

   always_comb begin
      bus.imem_req_valid = 1'b0;
      mis_push           = 1'b0;
      resp_push          = 1'b0;
      unique case (state_q)
         S_REQ: begin
            mis_push           = !rst && !flush && slot_free && pc_misalign;
            bus.imem_req_valid = !rst && !flush && slot_free && !pc_misalign;
         end
         S_WAIT:  resp_push = bus.imem_resp_valid && !flush;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (req_fire) req_pc <= pc_in;
   end

   // Fetch buffer: circular storage, head read combinationally.
   assign push       = resp_push | mis_push;
   assign pop        = bus.if_valid & bus.if_ready;
   assign push_pc    = mis_push ? pc_in : req_pc;
   assign push_instr = mis_push ? NOP : bus.imem_resp_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      occ <= occ + CW'(1);
         else if (pop && !push) occ <= occ - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
`ifdef FETCH_MISALIGN_EN
         mis_mem[wr_ptr]   <= mis_push;
`endif
      end
   end

   assign bus.if_valid = occ != '0;
   assign bus.if_pc    = bus.if_valid ? pc_mem[rd_ptr] : '0;
   assign bus.if_instr = bus.if_valid ? instr_mem[rd_ptr] : '0;
`ifdef FETCH_MISALIGN_EN
   assign bus.if_misalign = bus.if_valid & mis_mem[rd_ptr];
`else
   assign bus.if_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against a queue-based fetch model.
module tb_instruction_fetch;
   localparam int N     = 32;
   localparam int DEPTH = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] pc_in;
   logic         pc_advance;
   logic         flush;

   instruction_fetch_if #(.N(N)) bus ();

   instruction_fetch #(.N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .pc_in     (pc_in),
      .pc_advance(pc_advance),
      .flush     (flush),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0] pc;
      logic [N-1:0] instr;
      logic         mis;
   } entry_t;

   // Reference model: what decode should see, and whether a fetch is in flight.
   entry_t       q[$];
   bit           outstanding, out_live;
   logic [N-1:0] out_pc;
   logic [N-1:0] m_pc;
   // Memory model: one pending response with a countdown.
   bit           mem_busy;
   int           mem_cnt;
   logic [N-1:0] mem_word_q;
   // Per-cycle stimulus knobs.
   bit           k_rst, k_flush, k_if_ready, k_req_ready, k_fixed;
   int           k_lat;
   logic [N-1:0] k_word, k_target;
   // Last-cycle observations.
   bit           obs_adv, obs_valid, obs_req_valid, obs_mis;
   logic [N-1:0] obs_addr, obs_pc, obs_instr;

   int n_checks, n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] hashw(input logic [N-1:0] a);
      return {a[15:0], a[31:16]} ^ 32'h3C5A96E1;
   endfunction

   task automatic cycle();
      bit     resp, e_valid, e_req, e_mis, e_adv, pop, fire;
      entry_t head, e;
      rst                 = k_rst;
      flush               = k_flush;
      bus.if_ready        = k_if_ready;
      bus.imem_req_ready  = k_req_ready;
      pc_in               = m_pc;
      resp                = mem_busy && mem_cnt == 0;
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = resp ? mem_word_q : $urandom();
      #1;
      if (k_rst) begin
         q.delete();
         outstanding = 0;
         out_live    = 0;
      end
      e_valid = q.size() != 0;
      head    = e_valid ? q[0] : '0;
      e_mis   = 0;
`ifdef FETCH_MISALIGN_EN
      e_mis   = !k_rst && !k_flush && !outstanding && q.size() < DEPTH && m_pc[1:0] != 2'b00;
`endif
      e_req   = !k_rst && !k_flush && !outstanding && q.size() < DEPTH && !e_mis;
      fire    = e_req && k_req_ready;
      e_adv   = fire || e_mis;
      pop     = e_valid && k_if_ready;

      chk("if_valid", 32'(bus.if_valid), 32'(e_valid));
      if (e_valid) begin
         chk("if_pc", bus.if_pc, head.pc);
         chk("if_instr", bus.if_instr, head.instr);
         chk("if_misalign", 32'(bus.if_misalign), 32'(head.mis));
      end
      chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(e_req));
      if (e_req) chk("imem_req_addr", bus.imem_req_addr, m_pc);
      chk("pc_advance", 32'(pc_advance), 32'(e_adv));

      obs_adv       = pc_advance;
      obs_valid     = bus.if_valid;
      obs_req_valid = bus.imem_req_valid;
      obs_addr      = bus.imem_req_addr;
      obs_pc        = bus.if_pc;
      obs_instr     = bus.if_instr;
      obs_mis       = bus.if_misalign;

      if (!k_rst) begin
         if (k_flush) begin
            q.delete();
            if (outstanding) begin
               if (resp) outstanding = 0;
               else      out_live    = 0;
            end
         end else begin
            if (pop) void'(q.pop_front());
            if (outstanding && resp) begin
               if (out_live) begin
                  e = '{pc: out_pc, instr: mem_word_q, mis: 1'b0};
                  q.push_back(e);
               end
               outstanding = 0;
            end
            if (e_mis) begin
               e = '{pc: m_pc, instr: 32'h00000013, mis: 1'b1};
               q.push_back(e);
            end
         end
      end
      if (fire) begin
         outstanding = 1;
         out_live    = 1;
         out_pc      = m_pc;
      end

      if (resp)          mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (fire) begin
         mem_busy   = 1;
         mem_cnt    = k_lat - 1;
         mem_word_q = k_fixed ? k_word : hashw(m_pc);
      end

      if (k_flush)    m_pc = k_target;
      else if (e_adv) m_pc = m_pc + 32'd4;
      @(negedge clk);
   endtask

   task automatic drain();
      k_req_ready = 0;
      k_if_ready  = 1;
      k_flush     = 0;
      for (int i = 0; i < 50 && (mem_busy || outstanding || q.size() != 0); i++) cycle();
      chk("drain_timeout", 32'(mem_busy || outstanding || q.size() != 0), 32'd0);
   endtask

   task automatic redirect(input logic [N-1:0] target);
      k_flush  = 1;
      k_target = target;
      cycle();
      k_flush  = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, val, n_acc, n_v;
      logic [N-1:0] fpc, fins;
      n_checks = 0; n_fail = 0;
      q.delete(); outstanding = 0; out_live = 0; out_pc = '0;
      mem_busy = 0; mem_cnt = 0; mem_word_q = '0;
      m_pc = 32'h80000000;
      k_rst = 1; k_flush = 0; k_if_ready = 1; k_req_ready = 1;
      k_fixed = 1; k_word = 32'h00500093; k_lat = 1; k_target = '0;
      rst = 1; flush = 0; pc_in = m_pc;
      bus.if_ready = 1; bus.imem_req_ready = 1;
      bus.imem_resp_valid = 0; bus.imem_resp_data = '0;
      @(negedge clk);

      cycle();
      chk("rst_if_pc", obs_pc, 32'h0);
      chk("rst_if_instr", obs_instr, 32'h0);
      chk("rst_if_misalign", 32'(obs_mis), 32'd0);
      k_rst = 0;

      // Single fetch, 1-cycle memory.
      acc = -1; val = -1; fpc = '0; fins = '0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (obs_adv && acc < 0) acc = i;
         if (obs_valid && val < 0) begin
            val = i; fpc = obs_pc; fins = obs_instr;
         end
      end
      chk("t1_latency", 32'(val - acc), 32'd2);
      chk("t1_pc", fpc, 32'h80000000);
      chk("t1_instr", fins, 32'h00500093);
      drain();

      // Back-pressure fills both slots, then drains in order.
      redirect(32'h80000000);
      k_fixed = 0; k_if_ready = 0; k_req_ready = 1; k_lat = 1; n_acc = 0;
      repeat (10) begin
         cycle();
         n_acc += int'(obs_adv);
      end
      chk("t2_accepts", 32'(n_acc), 32'd2);
      chk("t2_req_stalled", 32'(obs_req_valid), 32'd0);
      k_if_ready = 1;
      cycle();
      chk("t2_head0", obs_pc, 32'h80000000);
      cycle();
      chk("t2_head1", obs_pc, 32'h80000004);
      n_acc = 0;
      repeat (6) begin
         cycle();
         n_acc += int'(obs_adv);
      end
      chk("t2_resume", 32'(n_acc > 0), 32'd1);
      drain();

      // Flush while waiting; the late response must be dropped.
      redirect(32'h80000040);
      k_fixed = 1; k_word = 32'hDEADBEEF; k_lat = 4; k_req_ready = 1;
      cycle();
      chk("t3_accept", 32'(obs_adv), 32'd1);
      k_req_ready = 0;
      redirect(32'h80000100);
      k_fixed = 0; n_v = 0;
      repeat (6) begin
         cycle();
         n_v += int'(obs_valid);
      end
      chk("t3_no_valid", 32'(n_v), 32'd0);
      k_req_ready = 1;
      cycle();
      chk("t3_addr", obs_addr, 32'h80000100);
      chk("t3_adv", 32'(obs_adv), 32'd1);
      drain();

      // Flush in the same cycle as the response.
      k_lat = 3; k_req_ready = 1;
      cycle();
      k_req_ready = 0;
      for (int i = 0; i < 10 && !(mem_busy && mem_cnt == 0); i++) cycle();
      redirect(32'h80000200);
      cycle();
      chk("t4_empty", 32'(obs_valid), 32'd0);
      chk("t4_back_in_req", 32'(obs_req_valid), 32'd1);
      drain();

      // Reset while waiting, then a late response.
      k_lat = 5; k_req_ready = 1;
      cycle();
      k_req_ready = 0;
      cycle();
      k_rst = 1;
      cycle();
      chk("t5_if_valid", 32'(obs_valid), 32'd0);
      chk("t5_if_pc", obs_pc, 32'h0);
      chk("t5_if_instr", obs_instr, 32'h0);
      chk("t5_if_misalign", 32'(obs_mis), 32'd0);
      chk("t5_adv", 32'(obs_adv), 32'd0);
      chk("t5_req_valid", 32'(obs_req_valid), 32'd0);
      k_rst = 0; n_v = 0;
      repeat (6) begin
         cycle();
         n_v += int'(obs_valid);
      end
      chk("t5_no_push", 32'(n_v), 32'd0);
      drain();

`ifdef FETCH_MISALIGN_EN
      redirect(32'h80000002);
      k_req_ready = 1; k_if_ready = 0;
      cycle();
      chk("t6_no_req", 32'(obs_req_valid), 32'd0);
      chk("t6_adv", 32'(obs_adv), 32'd1);
      cycle();
      chk("t6_valid", 32'(obs_valid), 32'd1);
      chk("t6_instr", obs_instr, 32'h00000013);
      chk("t6_flag", 32'(obs_mis), 32'd1);
      drain();
`endif

      // Random traffic against the model.
      redirect(32'h80001000);
      k_fixed = 0;
      repeat (2000) begin
         k_req_ready = $urandom_range(0, 9) < 7;
         k_if_ready  = $urandom_range(0, 9) < 6;
         k_flush     = $urandom_range(0, 49) == 0;
         k_lat       = $urandom_range(1, 4);
         k_target    = $urandom() & 32'hFFFFFFFC;
`ifdef FETCH_MISALIGN_EN
         if ($urandom_range(0, 3) == 0) k_target = k_target | 32'h2;
`endif
         cycle();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
